// File: rtl/iter_mul_div_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
//   MulDivOp      : operation select (unsigned/signed multiply, unsigned/signed divide)
//   StrcInMulDiv  : request bundle {oper, a, b} at the default CPU width
//   StrcOutMulDiv : response bundle {hi, lo, div_zero} at the default CPU width
//   md_is_div / md_is_signed : operation decode; any unknown code decodes as MD_UMul
package iter_mul_div_pkg;

  localparam int unsigned muldiv_width = 32;

  typedef enum logic [1:0] {
    MD_UMul = 2'd0,
    MD_SMul = 2'd1,
    MD_UDiv = 2'd2,
    MD_SDiv = 2'd3
  } MulDivOp;

  typedef struct packed {
    MulDivOp                 oper;
    logic [muldiv_width-1:0] a;
    logic [muldiv_width-1:0] b;
  } StrcInMulDiv;

  typedef struct packed {
    logic [muldiv_width-1:0] hi;
    logic [muldiv_width-1:0] lo;
    logic                    div_zero;
  } StrcOutMulDiv;

  function automatic logic md_is_div(MulDivOp op);
    case (op)
      MD_UDiv, MD_SDiv: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

  function automatic logic md_is_signed(MulDivOp op);
    case (op)
      MD_SMul, MD_SDiv: return 1'b1;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/iter_mul_div_if.sv
// Request/response bundle between the execute-stage control and the mul/div unit.
//   master : control side, drives flush, request (in_valid/in_oper/in_a/in_b) and out_ready
//   slave  : unit side, drives in_ready, result (out_valid/out_hi/out_lo/out_div_zero), busy
interface iter_mul_div_if
  import iter_mul_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) ();

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  MulDivOp          in_oper;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_hi;
  logic [WIDTH-1:0] out_lo;
  logic             out_div_zero;
  logic             busy;

  modport master (
    output flush, in_valid, in_oper, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_hi, out_lo, out_div_zero, busy
  );

  modport slave (
    input  flush, in_valid, in_oper, in_a, in_b, out_ready,
    output in_ready, out_valid, out_hi, out_lo, out_div_zero, busy
  );

endinterface

// File: rtl/iter_mul_div_step.sv
// One combinational radix-2 iteration over the {acc, lo} working pair.
//   is_div_i : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_i/o  : upper half (partial product / partial remainder)
//   lo_i/o   : lower half (multiplier bits / dividend bits becoming quotient)
//   b_i      : multiplicand / divisor magnitude
// The intermediate sum and shifted remainder are WIDTH+1 bits; the stored acc always fits
// in WIDTH bits because a remainder is always below the divisor.
module iter_mul_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] diff;

  always_comb begin
    // Multiply: add b when the current multiplier LSB is set, then shift {sum, lo} right.
    sum  = {1'b0, acc_i} + (lo_i[0] ? {1'b0, b_i} : '0);
    // Divide: shift the next dividend bit into the partial remainder and trial-subtract.
    shl  = {acc_i, lo_i[WIDTH-1]};
    diff = shl[WIDTH-1:0] - b_i;
    if (is_div_i) begin
      if (shl >= {1'b0, b_i}) begin
        acc_o = diff;
        lo_o  = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = shl[WIDTH-1:0];
        lo_o  = {lo_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = sum[WIDTH:1];
      lo_o  = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/iter_mul_div.sv
// Multi-cycle integer multiply/divide unit, one bit per clock.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of iter_mul_div_if (request, result, flush, busy)
// Signed operands are reduced to magnitudes at accept; the sign fix-up (and the divide-by-zero
// override) is applied in one extra RUN cycle after the last iteration, so a result appears
// WIDTH+1 edges after accept (2 edges for a fast divide-by-zero).
module iter_mul_div
  import iter_mul_div_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter bit          FAST_DIV0 = 1'b1
) (
  input logic           clk,
  input logic           rst,
  iter_mul_div_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} md_state_e;

  md_state_e        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             fix_q, fix_d;  // iterations finished, next RUN edge applies fix-up
  logic             is_div_q, is_div_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] a_q, a_d;      // raw dividend, returned as remainder on divide-by-zero
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic             res_dz_q, res_dz_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic             op_div, op_sgn, in_a_neg, in_b_neg, in_div0;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] acc_step, lo_step;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] q_fix, r_fix;

  iter_mul_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .is_div_i(is_div_q),
    .acc_i   (acc_q),
    .lo_i    (lo_q),
    .b_i     (b_q),
    .acc_o   (acc_step),
    .lo_o    (lo_step)
  );

  always_comb begin
    op_div   = md_is_div(bus.in_oper);
    op_sgn   = md_is_signed(bus.in_oper);
    in_a_neg = op_sgn & bus.in_a[WIDTH-1];
    in_b_neg = op_sgn & bus.in_b[WIDTH-1];
    in_div0  = op_div & (bus.in_b == '0);
    // MIN maps to itself, which is its correct unsigned magnitude.
    a_mag    = in_a_neg ? (~bus.in_a + 1'b1) : bus.in_a;
    b_mag    = in_b_neg ? (~bus.in_b + 1'b1) : bus.in_b;

    prod     = {acc_q, lo_q};
    prod_fix = (neg_a_q ^ neg_b_q) ? (~prod + 1'b1) : prod;
    q_fix    = (neg_a_q ^ neg_b_q) ? (~lo_q + 1'b1) : lo_q;
    r_fix    = neg_a_q ? (~acc_q + 1'b1) : acc_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fix_d    = fix_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    div0_d   = div0_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    b_d      = b_q;
    a_d      = a_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    res_dz_d = res_dz_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          state_d  = StRun;
          is_div_d = op_div;
          neg_a_d  = in_a_neg;
          neg_b_d  = in_b_neg;
          div0_d   = in_div0;
          acc_d    = '0;
          lo_d     = a_mag;
          b_d      = b_mag;
          a_d      = bus.in_a;
          fix_d    = 1'b0;
          cnt_d    = (FAST_DIV0 && in_div0) ? '0 : CntW'(WIDTH - 1);
        end
      end
      StRun: begin
        if (fix_q) begin
          state_d = StDone;
          if (div0_q) begin
            res_hi_d = a_q;
            res_lo_d = '1;
            res_dz_d = 1'b1;
          end else if (is_div_q) begin
            res_hi_d = r_fix;
            res_lo_d = q_fix;
            res_dz_d = 1'b0;
          end else begin
            res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
            res_lo_d = prod_fix[WIDTH-1:0];
            res_dz_d = 1'b0;
          end
        end else begin
          acc_d = acc_step;
          lo_d  = lo_step;
          if (cnt_q == '0) begin
            fix_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Flush overrides everything, including a same-edge accept.
    if (bus.flush) begin
      state_d  = StIdle;
      fix_d    = 1'b0;
      res_hi_d = '0;
      res_lo_d = '0;
      res_dz_d = 1'b0;
    end

    in_ready_d  = (state_d == StIdle);
    out_valid_d = (state_d == StDone);
    busy_d      = (state_d == StRun);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      fix_q       <= 1'b0;
      is_div_q    <= 1'b0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      div0_q      <= 1'b0;
      acc_q       <= '0;
      lo_q        <= '0;
      b_q         <= '0;
      a_q         <= '0;
      res_hi_q    <= '0;
      res_lo_q    <= '0;
      res_dz_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fix_q       <= fix_d;
      is_div_q    <= is_div_d;
      neg_a_q     <= neg_a_d;
      neg_b_q     <= neg_b_d;
      div0_q      <= div0_d;
      acc_q       <= acc_d;
      lo_q        <= lo_d;
      b_q         <= b_d;
      a_q         <= a_d;
      res_hi_q    <= res_hi_d;
      res_lo_q    <= res_lo_d;
      res_dz_q    <= res_dz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.busy         = busy_q;
  assign bus.out_hi       = res_hi_q;
  assign bus.out_lo       = res_lo_q;
  assign bus.out_div_zero = res_dz_q;

endmodule

// File: tb/tb_iter_mul_div.sv
// Bench for iter_mul_div: a WIDTH=32 and a WIDTH=8 instance share one stimulus set;
// sel8 routes requests to one of them and muxes its outputs back for checking against an
// arithmetic reference model.
module tb_iter_mul_div;
  import iter_mul_div_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, in_valid, out_ready;
  MulDivOp     oper;
  logic [31:0] a, b;
  bit          sel8;
  int          w;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  iter_mul_div_if #(.WIDTH(32)) bus32 ();
  iter_mul_div_if #(.WIDTH(8))  bus8 ();

  iter_mul_div #(.WIDTH(32), .FAST_DIV0(1'b1)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));
  iter_mul_div #(.WIDTH(8),  .FAST_DIV0(1'b1)) u_dut8  (.clk(clk), .rst(rst), .bus(bus8));

  assign bus32.flush     = flush;
  assign bus32.in_valid  = in_valid & ~sel8;
  assign bus32.in_oper   = oper;
  assign bus32.in_a      = a;
  assign bus32.in_b      = b;
  assign bus32.out_ready = out_ready;
  assign bus8.flush      = flush;
  assign bus8.in_valid   = in_valid & sel8;
  assign bus8.in_oper    = oper;
  assign bus8.in_a       = a[7:0];
  assign bus8.in_b       = b[7:0];
  assign bus8.out_ready  = out_ready;

  logic        obs_in_ready, obs_out_valid, obs_busy, obs_dz;
  logic [31:0] obs_hi, obs_lo;
  assign obs_in_ready  = sel8 ? bus8.in_ready : bus32.in_ready;
  assign obs_out_valid = sel8 ? bus8.out_valid : bus32.out_valid;
  assign obs_busy      = sel8 ? bus8.busy : bus32.busy;
  assign obs_dz        = sel8 ? bus8.out_div_zero : bus32.out_div_zero;
  assign obs_hi        = sel8 ? {24'h0, bus8.out_hi} : bus32.out_hi;
  assign obs_lo        = sel8 ? {24'h0, bus8.out_lo} : bus32.out_lo;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL w%0d %s: observed=%0h expected=%0h", w, tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic void model(input MulDivOp op, input longint unsigned ua,
                                input longint unsigned ub, input int wd,
                                output longint unsigned eh, output longint unsigned el,
                                output bit ed, output int lat);
    longint unsigned mask, up;
    longint          sa, sb, sp, sq, sr;
    mask = (64'd1 << wd) - 1;
    sa   = ua[wd-1] ? longint'(ua) - longint'(64'd1 << wd) : longint'(ua);
    sb   = ub[wd-1] ? longint'(ub) - longint'(64'd1 << wd) : longint'(ub);
    ed   = 1'b0;
    lat  = wd + 1;
    case (op)
      MD_UMul: begin
        up = ua * ub;
        eh = (up >> wd) & mask;
        el = up & mask;
      end
      MD_SMul: begin
        sp = sa * sb;
        up = longint'(sp);
        eh = (up >> wd) & mask;
        el = up & mask;
      end
      default: begin
        if (ub == 0) begin
          el  = mask;
          eh  = ua;
          ed  = 1'b1;
          lat = 2;
        end else if (op == MD_UDiv) begin
          el = ua / ub;
          eh = ua % ub;
        end else if (sa == -(longint'(1) << (wd - 1)) && sb == -1) begin
          el = 64'd1 << (wd - 1);
          eh = 0;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          el = longint'(sq) & mask;
          eh = longint'(sr) & mask;
        end
      end
    endcase
  endfunction

  task automatic run_op(input MulDivOp op, input logic [31:0] ra, input logic [31:0] rb,
                        input int hold);
    longint unsigned eh, el;
    bit              ed;
    int              elat, lat;
    logic [31:0]     msk, sh, sl;
    logic            sd;
    msk = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    model(op, longint'(ra & msk), longint'(rb & msk), w, eh, el, ed, elat);
    check("in_ready before accept", obs_in_ready, 1);
    oper      = op;
    a         = ra & msk;
    b         = rb & msk;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    check("busy after accept", obs_busy, 1);
    lat = 0;
    while (!obs_out_valid && lat < w + 8) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency op%0d", op), lat, elat);
    check($sformatf("hi op%0d a=%0h b=%0h", op, a, b), obs_hi, eh);
    check($sformatf("lo op%0d a=%0h b=%0h", op, a, b), obs_lo, el);
    check($sformatf("div_zero op%0d", op), obs_dz, ed);
    sh = obs_hi;
    sl = obs_lo;
    sd = obs_dz;
    // Offer a new request while stalled: it must be refused and the result must hold.
    for (int i = 0; i < hold; i++) begin
      oper     = MulDivOp'($urandom_range(0, 3));
      a        = $urandom & msk;
      b        = $urandom & msk;
      in_valid = 1'b1;
      @(negedge clk);
      check("stall in_ready", obs_in_ready, 0);
      check("stall out_valid", obs_out_valid, 1);
      check("stall hi", obs_hi, sh);
      check("stall lo", obs_lo, sl);
      check("stall dz", obs_dz, sd);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid after take", obs_out_valid, 0);
    check("in_ready after take", obs_in_ready, 1);
  endtask

  initial begin
    bit seen;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    oper      = MD_UMul;
    a         = '0;
    b         = '0;
    sel8      = 1'b0;
    w         = 32;

    for (int p = 0; p < 2; p++) begin
      sel8 = (p == 1);
      w    = (p == 1) ? 8 : 32;
      rst  = 1'b1;
      repeat (2) @(negedge clk);
      check("reset in_ready", obs_in_ready, 1);
      check("reset out_valid", obs_out_valid, 0);
      check("reset busy", obs_busy, 0);
      check("reset hi", obs_hi, 0);
      check("reset lo", obs_lo, 0);
      check("reset dz", obs_dz, 0);
      rst = 1'b0;
      @(negedge clk);

      // Directed cases; values are truncated to w bits.
      run_op(MD_UMul, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      run_op(MD_SMul, 32'hFFFF_FFFD, 32'd5, 0);
      run_op(MD_SDiv, 32'hFFFF_FFF9, 32'd2, 0);
      run_op(MD_UDiv, 32'd100, 32'd7, 0);
      run_op(MD_SDiv, 32'h1 << (w - 1), 32'hFFFF_FFFF, 0);
      run_op(MD_UDiv, 32'd5, 32'd0, 0);
      run_op(MD_SDiv, 32'hFFFF_FFFB, 32'd0, 0);
      run_op(MD_SMul, 32'hFFFF_FFFF, 32'd0, 0);
      run_op(MD_UMul, 32'h0000_00A5, 32'd1, 0);
      run_op(MD_UDiv, 32'hDEAD_BEEF, 32'd3, 10);
      run_op(MD_SMul, 32'h1 << (w - 1), 32'h1 << (w - 1), 0);

      for (int i = 0; i < 12; i++) begin
        int          sel;
        logic [31:0] rb;
        sel = $urandom_range(0, 7);
        rb  = (sel == 0) ? 32'd0 : (sel < 3) ? 32'($urandom_range(1, 15)) : $urandom;
        run_op(MulDivOp'($urandom_range(0, 3)), $urandom, rb, $urandom_range(0, 2));
      end

      // Flush mid-RUN, with a competing request on the same edge.
      oper     = MD_UDiv;
      a        = 32'd1000;
      b        = 32'd9;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat ((w == 32) ? 9 : 4) @(negedge clk);
      check("busy before flush", obs_busy, 1);
      flush    = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush in_ready", obs_in_ready, 1);
      check("flush busy", obs_busy, 0);
      check("flush out_valid", obs_out_valid, 0);
      seen = 1'b0;
      repeat (w + 5) begin
        @(negedge clk);
        if (obs_out_valid || obs_busy) seen = 1'b1;
      end
      check("no activity after flush", seen, 0);
      run_op(MD_SDiv, 32'hFFFF_FFF9, 32'd2, 0);

      // Asynchronous reset mid-RUN.
      oper     = MD_SMul;
      a        = 32'h0000_0013;
      b        = 32'hFFFF_FFFE;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("async rst in_ready", obs_in_ready, 1);
      check("async rst busy", obs_busy, 0);
      check("async rst out_valid", obs_out_valid, 0);
      check("async rst hi", obs_hi, 0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (w + 5) begin
        @(negedge clk);
        if (obs_out_valid) seen = 1'b1;
      end
      check("no result after rst", seen, 0);
      run_op(MD_UMul, 32'h0000_0007, 32'h0000_0009, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
